// File: rtl/collision_event_reader.sv
`default_nettype none
// ============================================================================
// Module      : collision_event_reader
// Description : Turns rising edges on a collision flag vector into a stream
//               of flag indices. Rising bits are collected in a pending mask.
//               A lowest-index-first scanner moves one pending bit per cycle
//               into a show-ahead event FIFO, which the host drains with
//               rd_en.
//               A rise on a bit that is still pending is merged into the
//               existing event and sets the sticky overflow flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1               system clock, rising edge
//   reset        in   1               synchronous, active-high reset
//   mod_enable   in   1               sampling enable
//   flags        in   FLAG_W          collision flag vector
//   flags_valid  in   1               sample strobe
//   rd_en        in   1               host pop request
//   clr_ovf      in   1               clears the overflow flag
//   evt_valid    out  1               FIFO not empty
//   evt_index    out  IDX_W           flag index at FIFO head, 0 when empty
//   evt_count    out  log2(DEPTH)+1   FIFO occupancy
//   overflow     out  1               sticky coalescing indicator
//   active_flags out  FLAG_W          last sampled flag vector
// ----------------------------------------------------------------------------
// Parameters
//   FLAG_W  number of flag bits
//   DEPTH   FIFO depth, power of two, at least 2
//   IDX_W   index width, 2**IDX_W >= FLAG_W
// ============================================================================
module collision_event_reader #(
   parameter int FLAG_W = 30,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mod_enable,
   input  logic [FLAG_W-1:0]        flags,
   input  logic                     flags_valid,
   input  logic                     rd_en,
   input  logic                     clr_ovf,
   output logic                     evt_valid,
   output logic [IDX_W-1:0]         evt_index,
   output logic [$clog2(DEPTH):0]   evt_count,
   output logic                     overflow,
   output logic [FLAG_W-1:0]        active_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // IDLE  : nothing pending
   // SCAN  : something pending and the FIFO has room
   // STALL : something pending and the FIFO is full; a grant can only go out
   //         together with a pop on the same edge
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [FLAG_W-1:0]   pending;
   logic [FLAG_W-1:0]   pending_next;
   logic [FLAG_W-1:0]   rise;
   logic [FLAG_W-1:0]   low_vec;
   logic [IDX_W-1:0]    low_idx;
   logic [FLAG_W-1:0]   grant_vec;
   logic                grant;
   logic                pop;
   logic                sample;
   logic                ovf_set;

   logic [IDX_W-1:0]    mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_next;

   assign sample = flags_valid & mod_enable;

   // New events are only the 0->1 transitions against the previous sample.
   assign rise = sample ? (flags & ~active_flags) : '0;

   // Lowest set bit of the registered pending mask.
   always_comb begin
      logic found;
      found   = 1'b0;
      low_idx = '0;
      low_vec = '0;
      for (int i = 0; i < FLAG_W; i++) begin
         if (!found && pending[i]) begin
            found      = 1'b1;
            low_idx    = IDX_W'(i);
            low_vec[i] = 1'b1;
         end
      end
   end

   // Next-state and datapath control. The state is rebuilt every edge from
   // the next pending mask and next occupancy, so IDLE always means the
   // pending register is empty and STALL always means the FIFO is full.
   always_comb begin
      grant        = 1'b0;
      pop          = rd_en && (count != '0);
      grant_vec    = '0;
      pending_next = pending;
      count_next   = count;
      ovf_set      = 1'b0;
      state_next   = IDLE;

      case (state)
         IDLE:    grant = 1'b0;
         SCAN:    grant = 1'b1;
         STALL:   grant = rd_en;
         default: grant = 1'b0;
      endcase

      if (grant) begin
         grant_vec = low_vec;
      end

      // A rise on a bit that is pending and not leaving this edge merges
      // into the existing event. A bit being granted on the same edge is
      // not merged: it gets a fresh pending bit and a second entry.
      ovf_set      = |(rise & pending & ~grant_vec);
      pending_next = (pending & ~grant_vec) | rise;

      case ({grant, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase

      if (pending_next == '0) begin
         state_next = IDLE;
      end else if (count_next == FULL_COUNT) begin
         state_next = STALL;
      end else begin
         state_next = SCAN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pending      <= '0;
         active_flags <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state   <= state_next;
         pending <= pending_next;
         count   <= count_next;

         if (sample) begin
            active_flags <= flags;
         end

         if (grant) begin
            mem[wr_ptr] <= low_idx;
            wr_ptr      <= wr_ptr + AW'(1);
         end

         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         // A new merge wins over a clear on the same edge.
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   assign evt_valid = (count != '0);
   assign evt_index = evt_valid ? mem[rd_ptr] : '0;
   assign evt_count = count;

endmodule
`default_nettype wire

// File: tb/tb_collision_event_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_event_reader
// Description : Self-checking bench for collision_event_reader: a vector
//               table, directed multi-cycle sequences and a randomized run
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_event_reader;

   localparam int FLAG_W = 30;
   localparam int DEPTH  = 8;
   localparam int IDX_W  = 5;

   logic                 clk;
   logic                 reset;
   logic                 mod_enable;
   logic [FLAG_W-1:0]    flags;
   logic                 flags_valid;
   logic                 rd_en;
   logic                 clr_ovf;
   logic                 evt_valid;
   logic [IDX_W-1:0]     evt_index;
   logic [3:0]           evt_count;
   logic                 overflow;
   logic [FLAG_W-1:0]    active_flags;

   int n_checks = 0;
   int n_fail   = 0;

   collision_event_reader #(
      .FLAG_W (FLAG_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mod_enable   (mod_enable),
      .flags        (flags),
      .flags_valid  (flags_valid),
      .rd_en        (rd_en),
      .clr_ovf      (clr_ovf),
      .evt_valid    (evt_valid),
      .evt_index    (evt_index),
      .evt_count    (evt_count),
      .overflow     (overflow),
      .active_flags (active_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [FLAG_W-1:0] m_act;
   logic [FLAG_W-1:0] m_pend;
   logic              m_ovf;
   int                m_q[$];

   task automatic model_step();
      logic [FLAG_W-1:0] r;
      logic [FLAG_W-1:0] gm;
      logic [FLAG_W-1:0] one;
      int g;
      if (reset) begin
         m_act  = '0;
         m_pend = '0;
         m_ovf  = 1'b0;
         m_q.delete();
         return;
      end
      one = 1;
      r = (mod_enable && flags_valid) ? (flags & ~m_act) : '0;
      g = -1;
      if (m_pend != '0 && (m_q.size() < DEPTH || rd_en)) begin
         for (int i = FLAG_W - 1; i >= 0; i--) begin
            if (m_pend[i]) g = i;
         end
      end
      gm = (g >= 0) ? (one << g) : '0;
      if ((r & m_pend & ~gm) != '0) m_ovf = 1'b1;
      else if (clr_ovf)             m_ovf = 1'b0;
      if (mod_enable && flags_valid) m_act = flags;
      m_pend = (m_pend & ~gm) | r;
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (g >= 0) m_q.push_back(g);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      int head;
      head = (m_q.size() > 0) ? m_q[0] : 0;
      check("model_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      check("model_index", 32'(evt_index), 32'(head));
      check("model_count", 32'(evt_count), 32'(m_q.size()));
      check("model_ovf",   32'(overflow),  32'(m_ovf));
      check("model_act",   32'(active_flags), 32'(m_act));
   endtask

   // One clock edge: advance the model with the pre-edge inputs, then
   // compare after the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic drive(input logic r, input logic en, input logic fv,
                        input logic rd, input logic clr, input logic [FLAG_W-1:0] fl);
      reset = r; mod_enable = en; flags_valid = fv; rd_en = rd; clr_ovf = clr; flags = fl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, flags);
         cycle();
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              rst, en, fv, rd, clr;
      logic [FLAG_W-1:0] fl;
      logic              ev;
      logic [IDX_W-1:0]  idx;
      logic [3:0]        cnt;
      logic              ovf;
      logic [FLAG_W-1:0] act;
   } vec_t;

   function automatic vec_t mk(logic rst, logic en, logic fv, logic rd, logic clr,
                               logic [FLAG_W-1:0] fl, logic ev, logic [IDX_W-1:0] idx,
                               logic [3:0] cnt, logic ovf, logic [FLAG_W-1:0] act);
      vec_t v;
      v.rst = rst; v.en = en; v.fv = fv; v.rd = rd; v.clr = clr; v.fl = fl;
      v.ev = ev; v.idx = idx; v.cnt = cnt; v.ovf = ovf; v.act = act;
      return v;
   endfunction

   vec_t vec [15];

   localparam logic [FLAG_W-1:0] B3 = 30'h8;
   localparam logic [FLAG_W-1:0] B4 = 30'h10;
   localparam logic [FLAG_W-1:0] B5 = 30'h20;
   localparam logic [FLAG_W-1:0] BURST = 30'b001000000111000000001111100101;

   int burst_exp [11] = '{0, 2, 5, 6, 7, 8, 9, 18, 19, 20, 27};

   initial begin
      int n10;
      int n12;
      int popped;
      logic [FLAG_W-1:0] fr;

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      //            rst en fv rd clr flags  ev idx cnt ovf act
      vec[0]  = mk(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, '0);
      vec[1]  = mk(0, 1, 1, 0, 0, B3, 0, 0, 0, 0, B3);
      vec[2]  = mk(0, 1, 0, 0, 0, B3, 1, 3, 1, 0, B3);
      vec[3]  = mk(0, 1, 0, 1, 0, B3, 0, 0, 0, 0, B3);
      vec[4]  = mk(0, 1, 1, 0, 0, B4, 0, 0, 0, 0, B4);
      vec[5]  = mk(0, 1, 1, 0, 0, B4, 1, 4, 1, 0, B4);
      vec[6]  = mk(0, 1, 1, 0, 0, B4, 1, 4, 1, 0, B4);
      vec[7]  = mk(0, 1, 1, 1, 0, B4, 0, 0, 0, 0, B4);
      vec[8]  = mk(0, 1, 1, 0, 0, B4, 0, 0, 0, 0, B4);
      vec[9]  = mk(0, 1, 1, 0, 0, '0, 0, 0, 0, 0, '0);
      vec[10] = mk(0, 1, 1, 0, 0, B4, 0, 0, 0, 0, B4);
      vec[11] = mk(0, 1, 0, 0, 0, B4, 1, 4, 1, 0, B4);
      vec[12] = mk(0, 0, 1, 0, 0, B5, 1, 4, 1, 0, B4);
      vec[13] = mk(0, 0, 0, 1, 0, '0, 0, 0, 0, 0, B4);
      vec[14] = mk(0, 0, 0, 1, 0, '0, 0, 0, 0, 0, B4);

      for (int i = 0; i < 15; i++) begin
         drive(vec[i].rst, vec[i].en, vec[i].fv, vec[i].rd, vec[i].clr, vec[i].fl);
         cycle();
         check($sformatf("vec%0d_valid", i), 32'(evt_valid),    32'(vec[i].ev));
         check($sformatf("vec%0d_index", i), 32'(evt_index),    32'(vec[i].idx));
         check($sformatf("vec%0d_count", i), 32'(evt_count),    32'(vec[i].cnt));
         check($sformatf("vec%0d_ovf", i),   32'(overflow),     32'(vec[i].ovf));
         check($sformatf("vec%0d_act", i),   32'(active_flags), 32'(vec[i].act));
      end

      // ---------- burst with backpressure ----------
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0); cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, BURST); cycle();
      idle(10);
      check("burst_count", 32'(evt_count), 32'd8);
      check("burst_fsm_stall", 32'(dut.state), 32'd2);
      for (int i = 0; i < 11; i++) begin
         check("burst_valid", 32'(evt_valid), 32'd1);
         check("burst_pop_idx", 32'(evt_index), 32'(burst_exp[i]));
         drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BURST); cycle();
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, BURST); cycle();
      check("burst_empty_count", 32'(evt_count), 32'd0);
      check("burst_empty_valid", 32'(evt_valid), 32'd0);
      check("burst_ovf", 32'(overflow), 32'd0);

      // ---------- coalescing, clear priority, full with pop ----------
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0); cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h4FF); cycle();
      idle(9);
      check("coal_full", 32'(evt_count), 32'd8);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0FF); cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h4FF); cycle();
      check("coal_ovf_set", 32'(overflow), 32'd1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0FF); cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 30'h4FF); cycle();
      check("ovf_set_beats_clr", 32'(overflow), 32'd1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h14FF); cycle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 30'h14FF); cycle();
      check("ovf_cleared", 32'(overflow), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h14FF); cycle();
      check("full_pop_push_count", 32'(evt_count), 32'd8);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h14FF); cycle();
      check("full_pop_push_count2", 32'(evt_count), 32'd8);
      n10 = 0; n12 = 0; popped = 0;
      for (int i = 0; i < 20 && evt_valid; i++) begin
         if (evt_index == 5'd10) n10++;
         if (evt_index == 5'd12) n12++;
         popped++;
         drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30'h14FF); cycle();
      end
      check("drain_timeout", 32'(evt_valid), 32'd0);
      check("coal_one_idx10", 32'(n10), 32'd1);
      check("idx12_once", 32'(n12), 32'd1);
      check("drain_entries", 32'(popped), 32'd8);

      // ---------- reset mid-operation ----------
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0); cycle();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h7FF); cycle();
      idle(5);
      check("mid_count5", 32'(evt_count), 32'd5);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 30'h7FF); cycle();
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_index", 32'(evt_index), 32'd0);
      check("rst_count", 32'(evt_count), 32'd0);
      check("rst_ovf",   32'(overflow),  32'd0);
      check("rst_act",   32'(active_flags), 32'd0);
      check("rst_fsm_idle", 32'(dut.state), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0); cycle();
      idle(4);
      check("rst_zero_strobe_valid", 32'(evt_valid), 32'd0);

      // ---------- randomized run against the model ----------
      fr = '0;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       fr = 30'($urandom) & 30'($urandom);
            1:       fr = fr ^ (30'(1) << $urandom_range(0, FLAG_W - 1));
            2:       fr = fr & 30'($urandom);
            default: fr = fr | (30'(1) << $urandom_range(0, FLAG_W - 1));
         endcase
         drive(1'($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 9) != 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 3),
               1'($urandom_range(0, 19) == 0),
               fr);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/collision_event_reader.md
COLLISION_EVENT_READER -- requirements
Module: collision_event_reader

Interface
REQ-001 Parameter FLAG_W, default 30, number of collision flag bits; flag index range 0..FLAG_W-1.
REQ-002 Parameter DEPTH, default 8, event FIFO depth in entries; SHALL be a power of two, at least 2.
REQ-003 Parameter IDX_W, default 5, event index width; SHALL satisfy 2^IDX_W >= FLAG_W.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mod_enable  input  1  sampling enable; when low, flags are not sampled.
REQ-007 flags  input  FLAG_W  collision flag vector from the collision block.
REQ-008 flags_valid  input  1  sample strobe; flags are sampled on an edge where flags_valid=1 and mod_enable=1.
REQ-009 rd_en  input  1  host pop request.
REQ-010 clr_ovf  input  1  clears the overflow flag.
REQ-011 evt_valid  output  1  FIFO not empty.
REQ-012 evt_index  output  IDX_W  flag index at the FIFO head (show-ahead).
REQ-013 evt_count  output  log2(DEPTH)+1  number of FIFO entries.
REQ-014 overflow  output  1  sticky coalescing indicator.
REQ-015 active_flags  output  FLAG_W  last sampled flag vector.

Function
REQ-016 On a sampling edge: active_flags <= flags; rise = flags & ~active_flags (previous value).
REQ-017 Pending mask update each edge: pending <= (pending & ~grant) | rise; rise = 0 on non-sampling edges.
REQ-018 Scanner selects the lowest-index set bit of pending, registered (pre-edge) value, as the grant; at most one grant per cycle.
REQ-019 A grant SHALL push its index into the FIFO and clear its pending bit on the same edge.
REQ-020 Grant is suppressed when the FIFO is full and rd_en=0; it is allowed when the FIFO is full and rd_en=1 (same-edge pop and push, count unchanged).
REQ-021 FSM states:
- IDLE: pending==0.
- SCAN: pending!=0 and a push is allowed.
- STALL: pending!=0 and the FIFO is full without pop.
Transitions are evaluated every edge from the next-state pending and FIFO count.
REQ-022 Latency: flags sampled at edge k with a new rising bit and an empty FIFO -> evt_valid=1 after edge k+1.
REQ-023 Ordering: events from one sample leave in ascending index order; events from earlier samples precede those from later samples only if already pushed.
REQ-024 Bits still pending when a later sample arrives are ordered by the lowest-index-first rule.
REQ-025 Pop: when rd_en=1 and evt_valid=1, the head is removed on that edge; rd_en with an empty FIFO is ignored and changes no state.
REQ-026 evt_index is the head entry whenever evt_valid=1, and 0 otherwise.
REQ-027 overflow <= 1 when rise has a bit already set in pending; that event is coalesced into one entry.
REQ-028 overflow is held until clr_ovf=1; if clr_ovf and a new overflow condition occur on the same edge, overflow SHALL be 1.
REQ-029 A flag that stays high across samples SHALL generate no further events; a fall followed by a rise generates a new event.
REQ-030 mod_enable=0: no sampling and active_flags held; the scanner and FIFO keep operating (drain continues).
REQ-031 No event is lost to backpressure; pending holds until FIFO space frees.

Reset
REQ-032 When reset=1 at an edge, every register SHALL take its reset value: pending=0, active_flags=0, FIFO empty, evt_valid=0, evt_index=0, evt_count=0, overflow=0, FSM=IDLE.
REQ-033 Reset SHALL take priority over all inputs; mid-operation reset discards queued and pending events.
REQ-034 The first sample after reset compares against all-zero, so every set bit produces an event.

Verification
REQ-035 Burst with backpressure: reset; flags=001000000111000000001111100101 strobed once, rd_en=0.
- FIFO holds 0,2,5,6,7,8,9,18; evt_count=8; FSM=STALL.
- Then rd_en=1 continuously pops 0,2,5,6,7,8,9,18,19,20,27; FIFO ends empty; overflow=0.
REQ-036 Single event latency: flags=bit 3 strobed at edge k -> evt_valid=1 and evt_index=3 after edge k+1; rd_en pops it -> evt_valid=0.
REQ-037 Steady flag: bit 4 held high over 5 strobes -> exactly one event (index 4).
- Then bit 4 low, then high -> a second event with index 4.
REQ-038 Coalescing: FIFO full, bit 10 pending; bit 10 falls and rises again -> overflow=1 and only one index-10 entry.
- clr_ovf=1 -> overflow=0 on the next edge.
REQ-039 Full with simultaneous pop: FIFO full, pending bit 12, rd_en=1 -> head popped, 12 pushed, evt_count stays 8.
REQ-040 Reset mid-operation: reset=1 while evt_count=5 and pending!=0 -> all outputs at reset values after that edge.
- A strobe of flags=0 then produces no events.
